systolic_tile_controller: RTL and testbench
===========================================

# systolic_tile_controller

Parametrised sequencer for the weight-stationary systolic array. It loads a filter group's weights, then streams a configurable number of IFM tiles through ping-pong IFM register files, with prefetch of tile t+1 overlapped with compute of tile t. It drains PE results column by column and loops over filter groups until done. It handles partial last filter groups, a programmable tile count, and a global stall for output back-pressure.

## Interface
- NO_FILTER, 16, total filters; G = ceil(NO_FILTER/SYSTOLIC_SIZE) filter groups
- KERNEL_SIZE, 3, kernel height/width
- NO_CHANNEL, 3, input channels; L = KERNEL_SIZE²·NO_CHANNEL load cycles
- SYSTOLIC_SIZE, 16, array dimension S; compute cycles per tile P = L + 2(S-1)
- NO_TILE, 4, IFM tiles per filter group T (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request, sampled in IDLE only
- stall  in  1  global hold (output sink not ready)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last drain
- load_wgt, select_wgt  out  1 each  weight RAM read / weight mux selects RAM
- wgt_rf_valid  out  S  per-column weight RF write enable
- load_ifm  out  1  IFM RAM read
- ifm_rf_valid  out  2  IFM bank write/shift enables, bit b = bank b
- select_demux_ifm  out  1  bank being filled
- select_mux_ifm  out  1  bank feeding the array
- pe_en  out  1  PE accumulate enable
- reset_pe  out  1  clear PE accumulators
- wr_en  out  1  output column write strobe
- wr_col  out  clog2(S)  column being written
- tile_idx  out  max(1,clog2(T))  tile of the data being written
- group_idx  out  max(1,clog2(G))  current filter group

## Operation
- States: IDLE, LOAD_WGT, COMPUTE, DRAIN, DONE. Phase counter c; tile t; group g.
- IDLE: all strobes 0. start=1 → LOAD_WGT, g=0.
- LOAD_WGT, c=0..L-1:
  - load_wgt=1, select_wgt=1, load_ifm=1, select_demux_ifm=0, ifm_rf_valid=01.
  - wgt_rf_valid = mask of active columns. All ones except when g=G-1 and NO_FILTER mod S ≠ 0; then the low (NO_FILTER mod S) bits are set.
  - At c=L-1 → COMPUTE, t=0, c=0.
- COMPUTE tile t, c=0..P-1:
  - select_mux_ifm=t[0], ifm_rf_valid[t[0]]=1, pe_en=1, select_wgt=0.
  - If t+1<T and c<L: load_ifm=1, select_demux_ifm=~t[0], ifm_rf_valid[~t[0]]=1. Otherwise the fill bank is idle.
  - reset_pe=1 at c=P-1 only.
  - If t>0: wr_en=1 for c=0..S-1, with wr_col=c and tile_idx=t-1 (drain of the previous tile overlaps compute).
  - At c=P-1: if t+1<T → COMPUTE with t+1; else → DRAIN.
- DRAIN, c=0..S-1: wr_en=1, wr_col=c, tile_idx=T-1.
  - At c=S-1: if g+1<G → LOAD_WGT with g+1; else → DONE.
- DONE: done=1 for one cycle → IDLE.
- Outputs are combinational decode of registered state/counters; all counters are registered.

## Timing
- start sampled at edge k gives the first LOAD_WGT output cycle k+1.
- Cycles per group = L + T·P + S. Total run = G·(L+T·P+S)+1 cycles including DONE.
- stall=1, any non-IDLE state:
  - state and counters hold.
  - load_wgt, load_ifm, ifm_rf_valid, wgt_rf_valid, pe_en, reset_pe and wr_en forced 0 in the same cycle.
  - selects, wr_col, tile_idx and group_idx hold.
  - Sequencing resumes exactly where it stopped.
- stall in IDLE has no effect.
- start while busy is ignored. start and stall together in IDLE: still enter LOAD_WGT.
- T=1: no prefetch ever; COMPUTE goes directly to DRAIN. G=1: DRAIN goes to DONE.
- S=1: wr_col width is 1 and always 0.
- Reset: rst=1 at any edge → IDLE, all counters 0, all outputs 0 from the next cycle. Mid-run reset drops the run; no done.

## Test plan
- Defaults (L=27, P=57, G=1), single start → busy high for exactly 271 cycles, then done for 1 cycle.
- Defaults: ifm_rf_valid=01 during LOAD_WGT; 11 for COMPUTE t=0, c=0..26; 01 for c=27..56.
- Defaults: wr_en runs 0..15 at the start of each of tiles 1..3, then in DRAIN. Total 64 wr_en pulses, each with the correct tile_idx.
- NO_FILTER=20 → two LOAD_WGT phases with wgt_rf_valid 0xFFFF then 0x000F. group_idx is 0 then 1.
- Pulse stall for 5 cycles at COMPUTE t=1, c=10 → all strobes 0 during the stall. Run length grows by exactly 5 and the strobe sequence is otherwise identical.
- Assert rst at DRAIN c=3, then restart → outputs 0 the cycle after reset, no done, and the clean run matches scenario 1.

Source files
------------

// File: rtl/systolic_tile_controller.sv
// systolic_tile_controller
// Sequencer for a weight-stationary systolic array. It loads one filter group's
// weights, streams NO_TILE IFM tiles through ping-pong IFM register banks while
// prefetching the next tile, and drains PE results column by column. It repeats
// this for every filter group. A global stall freezes sequencing and blanks all
// strobes. All strobes are a combinational decode of the registered
// state/counters.
module systolic_tile_controller #(
    parameter int NO_FILTER     = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NO_CHANNEL    = 3,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NO_TILE       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     load_wgt,
    output logic                     select_wgt,
    output logic [SYSTOLIC_SIZE-1:0] wgt_rf_valid,
    output logic                     load_ifm,
    output logic [1:0]               ifm_rf_valid,
    output logic                     select_demux_ifm,
    output logic                     select_mux_ifm,
    output logic                     pe_en,
    output logic                     reset_pe,
    output logic                     wr_en,
    output logic [((SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1)-1:0] wr_col,
    output logic [((NO_TILE > 1) ? $clog2(NO_TILE) : 1)-1:0]             tile_idx,
    output logic [((((NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE) > 1) ?
                   $clog2((NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE) : 1)-1:0] group_idx
);

    localparam int S    = SYSTOLIC_SIZE;
    localparam int L    = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
    localparam int P    = L + 2 * (S - 1);
    localparam int T    = NO_TILE;
    localparam int G    = (NO_FILTER + S - 1) / S;
    localparam int REM  = NO_FILTER % S;
    localparam int CW   = $clog2(P + 1);
    localparam int TW   = $clog2(T + 1);
    localparam int GW   = $clog2(G + 1);
    localparam int COLW = (S > 1) ? $clog2(S) : 1;
    localparam int TIW  = (T > 1) ? $clog2(T) : 1;
    localparam int GIW  = (G > 1) ? $clog2(G) : 1;

    // Column mask with the low n bits set, used for a partial last filter group.
    function automatic logic [S-1:0] low_mask(input int n);
        logic [S-1:0] m;
        m = '0;
        for (int i = 0; i < S; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [S-1:0] PART_MASK = low_mask(REM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_WGT,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   c_q;
    logic [TW-1:0]   t_q;
    logic [GW-1:0]   g_q;

    logic c_last_load;
    logic c_last_comp;
    logic c_last_drain;
    logic t_last;
    logic g_last;

    assign c_last_load  = (c_q == CW'(L - 1));
    assign c_last_comp  = (c_q == CW'(P - 1));
    assign c_last_drain = (c_q == CW'(S - 1));
    assign t_last       = (t_q == TW'(T - 1));
    assign g_last       = (g_q == GW'(G - 1));

    // Sequencer: state plus phase/tile/group counters; frozen while stalled outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            t_q     <= '0;
            g_q     <= '0;
        end else if (!(stall && (state_q != ST_IDLE))) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD_WGT;
                        c_q     <= '0;
                        t_q     <= '0;
                        g_q     <= '0;
                    end
                end
                ST_LOAD_WGT: begin
                    if (c_last_load) begin
                        state_q <= ST_COMPUTE;
                        c_q     <= '0;
                        t_q     <= '0;
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (c_last_comp) begin
                        c_q <= '0;
                        if (t_last) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (c_last_drain) begin
                        c_q <= '0;
                        if (g_last) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_LOAD_WGT;
                            g_q     <= g_q + GW'(1);
                        end
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    c_q     <= '0;
                    t_q     <= '0;
                    g_q     <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    c_q     <= '0;
                    t_q     <= '0;
                    g_q     <= '0;
                end
            endcase
        end
    end

    logic run;
    logic prefetch;
    logic wr_window;

    assign run       = ~stall;
    assign prefetch  = !t_last && (c_q < CW'(L));
    assign wr_window = (t_q != '0) && (c_q < CW'(S));

    // Output decode; strobes are blanked by stall, selects and indices keep their value.
    always_comb begin
        busy             = (state_q != ST_IDLE);
        done             = 1'b0;
        load_wgt         = 1'b0;
        select_wgt       = 1'b0;
        wgt_rf_valid     = '0;
        load_ifm         = 1'b0;
        ifm_rf_valid     = 2'b00;
        select_demux_ifm = 1'b0;
        select_mux_ifm   = 1'b0;
        pe_en            = 1'b0;
        reset_pe         = 1'b0;
        wr_en            = 1'b0;
        wr_col           = '0;
        tile_idx         = '0;
        group_idx        = GIW'(g_q);
        case (state_q)
            ST_LOAD_WGT: begin
                select_wgt = 1'b1;
                load_wgt   = run;
                load_ifm   = run;
                if (run) begin
                    ifm_rf_valid = 2'b01;
                    wgt_rf_valid = (g_last && (REM != 0)) ? PART_MASK : '1;
                end
            end
            ST_COMPUTE: begin
                select_mux_ifm   = t_q[0];
                select_demux_ifm = ~t_q[0];
                pe_en            = run;
                reset_pe         = run && c_last_comp;
                if (run) begin
                    ifm_rf_valid[t_q[0]] = 1'b1;
                    if (prefetch) begin
                        load_ifm              = 1'b1;
                        ifm_rf_valid[~t_q[0]] = 1'b1;
                    end
                end
                if (wr_window) begin
                    wr_en    = run;
                    wr_col   = COLW'(c_q);
                    tile_idx = TIW'(t_q - TW'(1));
                end
            end
            ST_DRAIN: begin
                wr_en    = run;
                wr_col   = COLW'(c_q);
                tile_idx = TIW'(T - 1);
            end
            ST_DONE: begin
                done = run;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Testbench for systolic_tile_controller: two instances (defaults, and
// NO_FILTER=20 for a partial second group) compared cycle by cycle against a
// cycle list built from the sequencing rules.
module tb_systolic_tile_controller;

    localparam int S = 16;
    localparam int L = 27;
    localparam int P = L + 2 * (S - 1);
    localparam int T = 4;

    typedef logic [34:0] vec_t;

    logic clk;
    logic rst_a, rst_b, start_a, start_b, stall_a, stall_b;

    logic busy_a, done_a, lw_a, sw_a, li_a, dmx_a, mx_a, pe_a, rpe_a, wr_a;
    logic [15:0] wgt_a;
    logic [1:0]  ifm_a;
    logic [3:0]  col_a;
    logic [1:0]  tile_a;
    logic [0:0]  grp_a;

    logic busy_b, done_b, lw_b, sw_b, li_b, dmx_b, mx_b, pe_b, rpe_b, wr_b;
    logic [15:0] wgt_b;
    logic [1:0]  ifm_b;
    logic [3:0]  col_b;
    logic [1:0]  tile_b;
    logic [0:0]  grp_b;

    vec_t obs_a, obs_b;
    vec_t exp_q[$];

    int checks = 0;
    int errors = 0;

    systolic_tile_controller dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stall(stall_a),
        .busy(busy_a), .done(done_a), .load_wgt(lw_a), .select_wgt(sw_a),
        .wgt_rf_valid(wgt_a), .load_ifm(li_a), .ifm_rf_valid(ifm_a),
        .select_demux_ifm(dmx_a), .select_mux_ifm(mx_a), .pe_en(pe_a),
        .reset_pe(rpe_a), .wr_en(wr_a), .wr_col(col_a), .tile_idx(tile_a),
        .group_idx(grp_a)
    );

    systolic_tile_controller #(.NO_FILTER(20)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stall(stall_b),
        .busy(busy_b), .done(done_b), .load_wgt(lw_b), .select_wgt(sw_b),
        .wgt_rf_valid(wgt_b), .load_ifm(li_b), .ifm_rf_valid(ifm_b),
        .select_demux_ifm(dmx_b), .select_mux_ifm(mx_b), .pe_en(pe_b),
        .reset_pe(rpe_b), .wr_en(wr_b), .wr_col(col_b), .tile_idx(tile_b),
        .group_idx(grp_b)
    );

    assign obs_a = {busy_a, done_a, lw_a, sw_a, wgt_a, li_a, ifm_a, dmx_a, mx_a,
                    pe_a, rpe_a, wr_a, col_a, tile_a, grp_a};
    assign obs_b = {busy_b, done_b, lw_b, sw_b, wgt_b, li_b, ifm_b, dmx_b, mx_b,
                    pe_b, rpe_b, wr_b, col_b, tile_b, grp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int busy, input int dn, input int lw, input int sw,
                                input logic [15:0] wgt, input int li, input logic [1:0] ifm,
                                input int dmx, input int mx, input int pe, input int rpe,
                                input int wr, input int col, input int tile, input int grp);
        logic [3:0] c4;
        logic [1:0] t2;
        logic       g1;
        c4 = col[3:0];
        t2 = tile[1:0];
        g1 = grp[0];
        return {busy[0], dn[0], lw[0], sw[0], wgt, li[0], ifm, dmx[0], mx[0],
                pe[0], rpe[0], wr[0], c4, t2, g1};
    endfunction

    // A stalled cycle keeps selects and indices but drops every strobe.
    function automatic vec_t stalled(input vec_t v);
        vec_t r;
        r = v;
        r[7] = 1'b0; r[8] = 1'b0; r[9] = 1'b0; r[13:12] = 2'b00; r[14] = 1'b0;
        r[30:15] = '0; r[32] = 1'b0; r[33] = 1'b0;
        return r;
    endfunction

    // Expected output for every cycle of a complete unstalled run, DONE included.
    task automatic build(input int nf);
        int G, rem, pf, wr, b;
        logic [15:0] m;
        logic [1:0]  ifm;
        exp_q.delete();
        G   = (nf + S - 1) / S;
        rem = nf % S;
        for (int g = 0; g < G; g++) begin
            m = (g == G - 1 && rem != 0) ? 16'((1 << rem) - 1) : 16'hFFFF;
            for (int c = 0; c < L; c++)
                exp_q.push_back(mk(1, 0, 1, 1, m, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, g));
            for (int t = 0; t < T; t++) begin
                b = t % 2;
                for (int c = 0; c < P; c++) begin
                    pf  = (t + 1 < T && c < L) ? 1 : 0;
                    ifm = 2'b00;
                    ifm[b] = 1'b1;
                    if (pf != 0) ifm[1 - b] = 1'b1;
                    wr = (t > 0 && c < S) ? 1 : 0;
                    exp_q.push_back(mk(1, 0, 0, 0, 16'h0, pf, ifm, 1 - b, b, 1,
                                       (c == P - 1) ? 1 : 0, wr, wr != 0 ? c : 0,
                                       wr != 0 ? t - 1 : 0, g));
                end
            end
            for (int c = 0; c < S; c++)
                exp_q.push_back(mk(1, 0, 0, 0, 16'h0, 0, 2'b00, 0, 0, 0, 0, 1, c, T - 1, g));
        end
        exp_q.push_back(mk(1, 1, 0, 0, 16'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, G - 1));
    endtask

    // Drive one cycle's inputs, capture outputs at the falling edge, advance past the rising edge.
    task automatic step(input bit which, input logic strt, input logic stl, output vec_t o);
        if (which) begin
            start_b = strt; stall_b = stl;
        end else begin
            start_a = strt; stall_a = stl;
        end
        @(negedge clk);
        o = which ? obs_b : obs_a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a !== '0) begin
            errors++; $display("FAIL reset_a: got %h expected 0", obs_a);
        end
        checks++;
        if (obs_b !== '0) begin
            errors++; $display("FAIL reset_b: got %h expected 0", obs_b);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_single_run();
        vec_t o;
        int bc, dc, wc, seen_done;
        build(16);
        bc = 0; dc = 0; wc = 0; seen_done = 0;
        step(0, 1'b1, 1'b0, o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL single_idle: got %h expected 0", o);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            step(0, 1'b0, 1'b0, o);
            checks++;
            if (o !== exp_q[i]) begin
                errors++; $display("FAIL single_cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
            if (o[33]) begin dc++; seen_done = 1; end
            if (o[34] && seen_done == 0) bc++;
            if (o[7]) wc++;
        end
        step(0, 1'b0, 1'b0, o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL single_back_idle: got %h expected 0", o);
        end
        checks++;
        if (bc != 271) begin
            errors++; $display("FAIL single_busy_len: got %0d expected 271", bc);
        end
        checks++;
        if (dc != 1) begin
            errors++; $display("FAIL single_done_count: got %0d expected 1", dc);
        end
        checks++;
        if (wc != 64) begin
            errors++; $display("FAIL single_wr_count: got %0d expected 64", wc);
        end
    endtask

    task automatic test_partial_group();
        vec_t o;
        vec_t got[$];
        build(20);
        step(1, 1'b1, 1'b0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            step(1, 1'($urandom_range(0, 1)), 1'b0, o);
            got.push_back(o);
            checks++;
            if (o !== exp_q[i]) begin
                errors++; $display("FAIL partial_cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        step(1, 1'b0, 1'b0, o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL partial_back_idle: got %h expected 0", o);
        end
        checks++;
        if (got[0][30:15] !== 16'hFFFF || got[0][0] !== 1'b0) begin
            errors++; $display("FAIL partial_g0_mask: got %h/%b expected ffff/0", got[0][30:15], got[0][0]);
        end
        checks++;
        if (got[271][30:15] !== 16'h000F || got[271][0] !== 1'b1) begin
            errors++; $display("FAIL partial_g1_mask: got %h/%b expected 000f/1", got[271][30:15], got[271][0]);
        end
    endtask

    task automatic test_stall();
        vec_t o;
        int cyc;
        build(16);
        cyc = 0;
        step(0, 1'b1, 1'b0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == L + P + 10) begin
                for (int s = 0; s < 5; s++) begin
                    step(0, 1'b0, 1'b1, o);
                    cyc++;
                    checks++;
                    if (o !== stalled(exp_q[i])) begin
                        errors++; $display("FAIL stall_hold %0d: got %h expected %h", s, o, stalled(exp_q[i]));
                    end
                end
            end
            step(0, 1'b0, 1'b0, o);
            cyc++;
            checks++;
            if (o !== exp_q[i]) begin
                errors++; $display("FAIL stall_cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        step(0, 1'b0, 1'b0, o);
        checks++;
        if (o[34] !== 1'b0 || cyc != 277) begin
            errors++; $display("FAIL stall_length: got busy=%b cycles=%0d expected busy=0 cycles=277", o[34], cyc);
        end
    endtask

    task automatic test_random_stall();
        vec_t o;
        int k, cyc, tot;
        build(20);
        cyc = 0; tot = 0;
        step(1, 1'b1, 1'b1, o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL rstall_idle: got %h expected 0", o);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            tot += k;
            for (int s = 0; s < k; s++) begin
                step(1, 1'($urandom_range(0, 1)), 1'b1, o);
                cyc++;
                checks++;
                if (o !== stalled(exp_q[i])) begin
                    errors++; $display("FAIL rstall_hold %0d: got %h expected %h", i, o, stalled(exp_q[i]));
                end
            end
            step(1, 1'($urandom_range(0, 1)), 1'b0, o);
            cyc++;
            checks++;
            if (o !== exp_q[i]) begin
                errors++; $display("FAIL rstall_cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        step(1, 1'b0, 1'b0, o);
        checks++;
        if (o[34] !== 1'b0 || cyc != exp_q.size() + tot) begin
            errors++; $display("FAIL rstall_length: got busy=%b cycles=%0d expected busy=0 cycles=%0d",
                               o[34], cyc, exp_q.size() + tot);
        end
    endtask

    task automatic test_reset_midrun();
        vec_t o;
        int bad;
        build(16);
        step(0, 1'b1, 1'b0, o);
        for (int i = 0; i <= L + T * P + 3; i++) begin
            if (i == L + T * P + 3) rst_a = 1'b1;
            step(0, 1'b0, 1'b0, o);
            checks++;
            if (o !== exp_q[i]) begin
                errors++; $display("FAIL midrst_cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        rst_a = 1'b0;
        step(0, 1'b0, 1'b0, o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL midrst_after: got %h expected 0", o);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1'b0, 1'b0, o);
            if (o !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad);
        end
        test_single_run();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0;
        test_reset();
        test_single_run();
        test_partial_group();
        test_stall();
        test_random_stall();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
